// File: rtl/jogo_pkg.sv
// Shared widths, button encodings and the fixed move sequence for the memory game datapath.
package jogo_pkg;

   localparam int unsigned N_ADDR    = 4;
   localparam int unsigned N_DADO    = 4;
   localparam int unsigned ROM_DEPTH = 2 ** N_ADDR;

   typedef logic [N_DADO-1:0] jogada_t;

   localparam jogada_t BOTAO0 = 4'b0001;
   localparam jogada_t BOTAO1 = 4'b0010;
   localparam jogada_t BOTAO2 = 4'b0100;
   localparam jogada_t BOTAO3 = 4'b1000;

   // Sequence the player must reproduce, one one-hot move per address.
   localparam jogada_t ROM_SEQ [0:ROM_DEPTH-1] = '{
      BOTAO0, BOTAO1, BOTAO2, BOTAO3,
      BOTAO2, BOTAO1, BOTAO0, BOTAO0,
      BOTAO1, BOTAO1, BOTAO2, BOTAO2,
      BOTAO3, BOTAO3, BOTAO0, BOTAO2
   };

endpackage

// File: rtl/jogo_fluxo_dados_if.sv
// Command/status/debug bundle between the game control unit and its datapath.
interface jogo_fluxo_dados_if #(
   parameter int unsigned N_ADDR = jogo_pkg::N_ADDR,
   parameter int unsigned N_DADO = jogo_pkg::N_DADO
);
   logic              zeraC;
   logic              contaC;
   logic              zeraR;
   logic              registraR;
   logic [N_DADO-1:0] botoes;
   logic              jogada_feita;
   logic              igual;
   logic              fim;
   logic [N_ADDR-1:0] db_contagem;
   logic [N_DADO-1:0] db_memoria;
   logic [N_DADO-1:0] db_jogada;
   logic              db_tem_jogada;

   modport master (
      output zeraC, contaC, zeraR, registraR, botoes,
      input  jogada_feita, igual, fim,
             db_contagem, db_memoria, db_jogada, db_tem_jogada
   );

   modport slave (
      input  zeraC, contaC, zeraR, registraR, botoes,
      output jogada_feita, igual, fim,
             db_contagem, db_memoria, db_jogada, db_tem_jogada
   );
endinterface

// File: rtl/jogo_fluxo_dados_detector_borda.sv
// Single-bit rising-edge detector; pulse lasts from the rise until the next clock edge.
module detector_borda (
   input  logic clock,
   input  logic reset,
   input  logic sinal_i,
   output logic borda_o
);

   logic d_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) d_q <= 1'b0;
      else       d_q <= sinal_i;
   end

   assign borda_o = sinal_i & ~d_q;

endmodule

// File: rtl/jogo_fluxo_dados.sv
// Memory game datapath: address counter, sequence ROM, move register, comparator, press detector.
module jogo_fluxo_dados #(
   parameter int unsigned N_ADDR = jogo_pkg::N_ADDR,
   parameter int unsigned N_DADO = jogo_pkg::N_DADO
) (
   input  logic              clock,
   input  logic              reset,
   jogo_fluxo_dados_if.slave dp
);
   import jogo_pkg::*;

   logic [N_ADDR-1:0] cont_q, cont_d;
   logic [N_DADO-1:0] jog_q, jog_d;
   logic [N_DADO-1:0] mem_c;
   logic              tem_c;

   // Counter: clear wins over count; wraps naturally at the top address.
   always_comb begin
      cont_d = cont_q;
      if (dp.zeraC)       cont_d = '0;
      else if (dp.contaC) cont_d = cont_q + N_ADDR'(1);
   end

   // Move register: clear wins over load; multi-button values stored as-is.
   always_comb begin
      jog_d = jog_q;
      if (dp.zeraR)          jog_d = '0;
      else if (dp.registraR) jog_d = dp.botoes;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cont_q <= '0;
         jog_q  <= '0;
      end else begin
         cont_q <= cont_d;
         jog_q  <= jog_d;
      end
   end

   assign mem_c = N_DADO'(ROM_SEQ[cont_q]);
   assign tem_c = |dp.botoes;

   detector_borda u_borda (
      .clock   (clock),
      .reset   (reset),
      .sinal_i (tem_c),
      .borda_o (dp.jogada_feita)
   );

   assign dp.igual         = (mem_c == jog_q);
   assign dp.fim           = (cont_q == {N_ADDR{1'b1}});
   assign dp.db_contagem   = cont_q;
   assign dp.db_memoria    = mem_c;
   assign dp.db_jogada     = jog_q;
   assign dp.db_tem_jogada = tem_c;

endmodule
